// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, shared-ALU and response signal bundle for alu_arbiter
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [3:0]  req0_sel;
   logic        req1_valid;
   logic        req1_ready;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [3:0]  req1_sel;
   logic [31:0] alu_srcA;
   logic [31:0] alu_srcB;
   logic [3:0]  alu_sel;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;

   // requesters, shared ALU and response consumer
   modport master (
      output req0_valid, req0_a, req0_b, req0_sel,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sel,
      input  req1_ready,
      input  alu_srcA, alu_srcB, alu_sel,
      output alu_result,
      input  rsp_valid, rsp_id, rsp_result,
      output rsp_ready
   );

   // the arbiter itself
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sel,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sel,
      output req1_ready,
      output alu_srcA, alu_srcB, alu_sel,
      input  alu_result,
      output rsp_valid, rsp_id, rsp_result,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin arbiter in front of a shared combinational ALU; optional stall counters under ALU_ARB_STALL_CNT_EN
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   alu_arbiter_if.slave     bus
`ifdef ALU_ARB_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt0,
   output logic [CNT_W-1:0] stall_cnt1
`endif
);

   if (CNT_W < 4 || CNT_W > 32) begin : g_bad_cnt_w
      $error("alu_arbiter: CNT_W must be within 4..32");
   end

   // operand stage
   logic        op_valid;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_sel;
   logic        op_id;

   // response stage
   logic        rsp_valid_q;
   logic [31:0] rsp_result_q;
   logic        rsp_id_q;

   // 1 means requester 1 was granted most recently, so requester 0 wins the next tie
   logic        last_grant;

   logic        rsp_free;
   logic        op_adv;
   logic        op_accept;
   logic        gnt0;
   logic        gnt1;
   logic        rdy0;
   logic        rdy1;

   // pipeline flow control and grant decision
   always_comb begin
      rsp_free  = !rsp_valid_q || bus.rsp_ready;
      op_adv    = op_valid && rsp_free;
      op_accept = !op_valid || op_adv;
      gnt0      = bus.req0_valid && (!bus.req1_valid || last_grant);
      gnt1      = bus.req1_valid && (!bus.req0_valid || !last_grant);
      rdy0      = gnt0 && op_accept;
      rdy1      = gnt1 && op_accept;
   end

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.alu_srcA   = op_a;
   assign bus.alu_srcB   = op_b;
   assign bus.alu_sel    = op_sel;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_id     = rsp_id_q;

   // operand stage: load the granted request, or empty out keeping the old operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_valid <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_sel   <= '0;
         op_id    <= 1'b0;
      end else if (op_accept) begin
         if (rdy0) begin
            op_valid <= 1'b1;
            op_a     <= bus.req0_a;
            op_b     <= bus.req0_b;
            op_sel   <= bus.req0_sel;
            op_id    <= 1'b0;
         end else if (rdy1) begin
            op_valid <= 1'b1;
            op_a     <= bus.req1_a;
            op_b     <= bus.req1_b;
            op_sel   <= bus.req1_sel;
            op_id    <= 1'b1;
         end else begin
            op_valid <= 1'b0;
         end
      end
   end

   // remember who won the last real handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (rdy0) begin
         last_grant <= 1'b0;
      end else if (rdy1) begin
         last_grant <= 1'b1;
      end
   end

   // response stage: capture the ALU output when the operand stage advances
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_id_q     <= 1'b0;
      end else if (op_adv) begin
         rsp_valid_q  <= 1'b1;
         rsp_result_q <= bus.alu_result;
         rsp_id_q     <= op_id;
      end else if (bus.rsp_ready) begin
         rsp_valid_q  <= 1'b0;
      end
   end

`ifdef ALU_ARB_STALL_CNT_EN
   // count cycles each requester waits, saturating at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else begin
         if (bus.req0_valid && !rdy0 && (stall_cnt0 != {CNT_W{1'b1}})) begin
            stall_cnt0 <= stall_cnt0 + 1'b1;
         end
         if (bus.req1_valid && !rdy1 && (stall_cnt1 != {CNT_W{1'b1}})) begin
            stall_cnt1 <= stall_cnt1 + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - table-driven bench for alu_arbiter with hand sequences for backpressure and reset
module tb_alu_arbiter;
`ifdef ALU_ARB_STALL_CNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter_if bus ();

`ifdef ALU_ARB_STALL_CNT_EN
   logic [CW-1:0] stall_cnt0;
   logic [CW-1:0] stall_cnt1;
`endif

   alu_arbiter #(.CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus)
`ifdef ALU_ARB_STALL_CNT_EN
      ,
      .stall_cnt0 (stall_cnt0),
      .stall_cnt1 (stall_cnt1)
`endif
   );

   function automatic logic [31:0] alu_model(logic [31:0] a, logic [31:0] b, logic [3:0] s);
      case (s)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         default: return 32'd0;
      endcase
   endfunction

   assign bus.alu_result = alu_model(bus.alu_srcA, bus.alu_srcB, bus.alu_sel);

   typedef struct {
      logic        v0;
      logic        v1;
      logic [31:0] a0;
      logic [31:0] b0;
      logic [3:0]  s0;
      logic [31:0] a1;
      logic [31:0] b1;
      logic [3:0]  s1;
      logic        rr;
      logic        e_r0;
      logic        e_r1;
      logic        e_rv;
      logic        e_id;
      logic [31:0] e_res;
   } vec_t;

   function automatic vec_t mk(logic v0, logic v1, logic [31:0] a0, logic [31:0] b0, logic [3:0] s0,
                               logic [31:0] a1, logic [31:0] b1, logic [3:0] s1, logic rr,
                               logic e_r0, logic e_r1, logic e_rv, logic e_id, logic [31:0] e_res);
      vec_t v;
      v.v0 = v0; v.v1 = v1; v.a0 = a0; v.b0 = b0; v.s0 = s0;
      v.a1 = a1; v.b1 = b1; v.s1 = s1; v.rr = rr;
      v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_rv = e_rv; v.e_id = e_id; v.e_res = e_res;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic v0, logic v1, logic [31:0] a0, logic [31:0] b0, logic [3:0] s0,
                        logic [31:0] a1, logic [31:0] b1, logic [3:0] s1, logic rr);
      bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_sel = s0;
      bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_sel = s1;
      bus.rsp_ready  = rr;
   endtask

   vec_t tbl [17];
   int   n_acc;
   int   n_rsp;

   initial begin
      tbl[0]  = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 32'd0);
      tbl[1]  = mk(1,1, 100,1,0, 'hF0,'h0F,4, 1,  1,0,0,0, 32'd0);
      tbl[2]  = mk(1,1, 100,1,0, 'hF0,'h0F,4, 1,  0,1,0,0, 32'd0);
      tbl[3]  = mk(1,1, 100,1,0, 'hF0,'h0F,4, 1,  1,0,1,0, 32'd101);
      tbl[4]  = mk(1,1, 100,1,0, 'hF0,'h0F,4, 1,  0,1,1,1, 32'hFF);
      tbl[5]  = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,1,0, 32'd101);
      tbl[6]  = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,1,1, 32'hFF);
      tbl[7]  = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,0,1, 32'hFF);
      tbl[8]  = mk(1,0, 5,7,0, 0,0,0, 1,  1,0,0,1, 32'hFF);
      tbl[9]  = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,0,1, 32'hFF);
      tbl[10] = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,1,0, 32'd12);
      tbl[11] = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 32'd12);
      tbl[12] = mk(0,1, 0,0,0, 'hFF00FF00,'h0F0F0F0F,2, 1,  0,1,0,0, 32'd12);
      tbl[13] = mk(1,0, 1,2,3, 0,0,0, 1,  1,0,0,0, 32'd12);
      tbl[14] = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,1,1, 32'h0F000F00);
      tbl[15] = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,1,0, 32'd3);
      tbl[16] = mk(0,0, 0,0,0, 0,0,0, 1,  0,0,0,0, 32'd3);

      drive(0,0, 0,0,0, 0,0,0, 1);
      repeat (2) @(negedge clk);
      chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("reset_alu_srcA", bus.alu_srcA, 32'd0);
      rst = 1'b0;

      // directed vectors: tie after reset, single op, mixed ops
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         drive(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].s0,
               tbl[i].a1, tbl[i].b1, tbl[i].s1, tbl[i].rr);
         #1;
         chk($sformatf("row%0d_req0_ready", i), {31'd0, bus.req0_ready}, {31'd0, tbl[i].e_r0});
         chk($sformatf("row%0d_req1_ready", i), {31'd0, bus.req1_ready}, {31'd0, tbl[i].e_r1});
         chk($sformatf("row%0d_rsp_valid", i),  {31'd0, bus.rsp_valid},  {31'd0, tbl[i].e_rv});
         chk($sformatf("row%0d_rsp_id", i),     {31'd0, bus.rsp_id},     {31'd0, tbl[i].e_id});
         chk($sformatf("row%0d_rsp_result", i), bus.rsp_result,          tbl[i].e_res);
      end

      // backpressure: req1 SUB 10-3 streams while rsp_ready is held low for 5 cycles
      n_acc = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         drive(c >= 2, 1, 5,7,0, 10,3,1, 0);
         #1;
         if (bus.req1_valid && bus.req1_ready) n_acc++;
         if (c < 2) begin
            chk($sformatf("bp%0d_req1_ready", c), {31'd0, bus.req1_ready}, 32'd1);
         end else begin
            chk($sformatf("bp%0d_req0_ready", c), {31'd0, bus.req0_ready}, 32'd0);
            chk($sformatf("bp%0d_req1_ready", c), {31'd0, bus.req1_ready}, 32'd0);
            chk($sformatf("bp%0d_rsp_valid", c),  {31'd0, bus.rsp_valid},  32'd1);
            chk($sformatf("bp%0d_rsp_result", c), bus.rsp_result,          32'd7);
            chk($sformatf("bp%0d_rsp_id", c),     {31'd0, bus.rsp_id},     32'd1);
         end
      end
      n_rsp = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(0,0, 0,0,0, 0,0,0, 1);
         #1;
         if (bus.rsp_valid) begin
            n_rsp++;
            chk($sformatf("drain%0d_rsp_result", c), bus.rsp_result, 32'd7);
            chk($sformatf("drain%0d_rsp_id", c), {31'd0, bus.rsp_id}, 32'd1);
         end
      end
      chk("bp_accept_count", n_acc, 32'd2);
      chk("bp_response_count", n_rsp, 32'd2);

      // reset while both stages hold an operation
      @(negedge clk);
      drive(1,0, 5,7,0, 0,0,0, 0);
      #1;
      chk("rf_first_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      @(negedge clk);
      #1;
      chk("rf_second_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      @(negedge clk);
      drive(0,0, 0,0,0, 0,0,0, 0);
      #1;
      chk("rf_rsp_valid_before", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rf_alu_srcA_before", bus.alu_srcA, 32'd5);
      rst = 1'b1;
      #1;
      chk("rf_rsp_valid_async", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rf_rsp_result_async", bus.rsp_result, 32'd0);
      chk("rf_alu_srcA_async", bus.alu_srcA, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      n_rsp = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
         if (bus.rsp_valid) n_rsp++;
      end
      chk("rf_responses_after_release", n_rsp, 32'd0);
      @(negedge clk);
      drive(1,1, 1,1,0, 2,2,0, 1);
      #1;
      chk("rf_tie_req0_ready", {31'd0, bus.req0_ready}, 32'd1);
      chk("rf_tie_req1_ready", {31'd0, bus.req1_ready}, 32'd0);

`ifdef ALU_ARB_STALL_CNT_EN
      // req1 starved by held backpressure: counter saturates at 15
      @(negedge clk);
      drive(0,0, 0,0,0, 0,0,0, 1);
      rst = 1'b1;
      #1;
      chk("stall_cnt1_reset", {28'd0, stall_cnt1}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(0,1, 0,0,0, 10,3,1, 0);
      repeat (20) @(negedge clk);
      #1;
      chk("stall_cnt1_saturated", {28'd0, stall_cnt1}, 32'd15);
      chk("stall_cnt0_idle", {28'd0, stall_cnt0}, 32'd0);
`endif

      @(negedge clk);
      drive(0,0, 0,0,0, 0,0,0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter CNT_W, default 16: width of each stall counter; legal range 4..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  32 each  requester 0 operands srcA and srcB.
REQ-007 req0_sel  input  4  requester 0 ALU operation code, team ALU encoding.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel: same as REQ-004..007 for requester 1.
REQ-009 alu_srcA, alu_srcB  output  32 each  operands driven to the shared ALU.
REQ-010 alu_sel  output  4  operation code driven to the shared ALU.
REQ-011 alu_result  input  32  combinational result returned by the shared ALU.
REQ-012 rsp_valid  output  1  response register holds a result.
REQ-013 rsp_ready  input  1  consumer takes the response this cycle.
REQ-014 rsp_id  output  1  requester that issued the held result (0 or 1).
REQ-015 rsp_result  output  32  held ALU result.
REQ-016 stall_cnt0, stall_cnt1  output  CNT_W each  wait counters; present only with ALU_ARB_STALL_CNT_EN.

Function
REQ-017 Two stages: operand stage (op_valid, op_a, op_b, op_sel, op_id) and response stage (rsp_valid, rsp_result, rsp_id).
REQ-018 alu_srcA/alu_srcB/alu_sel SHALL be driven directly from op_a/op_b/op_sel at all times.
REQ-019 Response stage SHALL be free when rsp_valid==0 or rsp_ready==1; operand stage SHALL advance only when response stage is free.
REQ-020 Operand stage SHALL accept when op_valid==0 or operand stage advances this cycle.
REQ-021 Grant: only one valid -> that requester; both valid -> requester not granted most recently (last_grant register).
REQ-022 reqN_ready SHALL equal (granted to N) AND (operand stage accepts); combinational, at most one ready high per cycle.
REQ-023 last_grant SHALL update only on an actual accept (valid AND ready).
REQ-024 Latency: request accepted at edge N -> rsp_valid high after edge N+1 with alu_result of those operands; throughput one per cycle while rsp_ready==1.
REQ-025 On advance, rsp_result<=alu_result, rsp_id<=op_id, rsp_valid<=1; if response drained and operand stage empty, rsp_valid<=0.
REQ-026 Operand stage empty and not refilled -> op_valid<=0, op_a/op_b/op_sel hold previous values.
REQ-027 rsp_valid high and rsp_ready low: rsp_result/rsp_id SHALL remain stable; both reqN_ready low if operand stage full.
REQ-028 No request lost or duplicated; responses SHALL leave in acceptance order.

Reset
REQ-029 rst high SHALL immediately clear op_valid, rsp_valid, op_a, op_b, op_sel, op_id, rsp_result, rsp_id to 0 and set last_grant to 1 (requester 0 wins first tie).
REQ-030 Reset mid-operation SHALL discard in-flight operations; no response for them after release.
REQ-031 Stall counters SHALL reset to 0.

Configuration
REQ-032 Macro ALU_ARB_STALL_CNT_EN defined: stall_cntN increments each cycle reqN_valid==1 and reqN_ready==0, saturating at all-ones, never wraps.
REQ-033 Macro undefined: stall_cnt0/stall_cnt1 ports and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-034 Single: req0 ADD a=5 b=7, rsp_ready=1 -> req0_ready same cycle, rsp_valid two edges later, rsp_result=12, rsp_id=0.
REQ-035 Tie after reset: both valid every cycle, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 with no bubbles.
REQ-036 Backpressure: rsp_ready=0 for 5 cycles with req1 SUB 10-3 streaming -> rsp_result holds 7, both readys low once operand stage full, no loss after release.
REQ-037 Reset mid-flight: assert rst with op_valid=1 and rsp_valid=1 -> both 0 asynchronously; no response after release.
REQ-038 With ALU_ARB_STALL_CNT_EN and CNT_W=4: req1 starved by held rsp_ready=0 for 20 cycles -> stall_cnt1 saturates at 15.
